bram_scan_ctrl: RTL and testbench

- Parametrised frame-buffer read controller.
- Follows incoming VGA timing (VSYNC/HSYNC/DE) and generates BRAM read addresses for a HSIZE x VSIZE RGB565 frame stored row-major from BASE_ADDR.
- Supports any combination of vertical flip and horizontal mirror.
- Realigns the sync signals to the BRAM read latency and expands the pixels to 8-bit-per-channel RGB for the video output stage.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/bram_scan_ctrl_sync_delay.sv | 27 ++
 rtl/bram_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_bram_scan_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer definitions: default geometry, RGB565 field layout
// and small helpers used by the scan controller.
package vga_pkg;
    localparam int HSIZE_DEF = 640;
    localparam int VSIZE_DEF = 480;

    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_B_MSB = 4;
    localparam int RGB565_B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

    // Replicate each channel's MSBs into the new LSBs so full scale maps to 0xFF.
    function automatic rgb888_t rgb565_to_888(input logic [15:0] d);
        rgb888_t p;
        p.r = {d[RGB565_R_MSB:RGB565_R_LSB], d[RGB565_R_MSB -: 3]};
        p.g = {d[RGB565_G_MSB:RGB565_G_LSB], d[RGB565_G_MSB -: 2]};
        p.b = {d[RGB565_B_MSB:RGB565_B_LSB], d[RGB565_B_MSB -: 3]};
        return p;
    endfunction
endpackage

// File: rtl/bram_scan_ctrl_sync_delay.sv
// Fixed-depth shift register for a bundle of sync/enable bits; also exposes
// the top bit one stage early so a downstream register can align to the output.
module sync_delay #(
    parameter int              DEPTH   = 3,
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_pre_msb
);
    logic [DEPTH:1][WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = {pipe_q[DEPTH-1:1], din};
    end

    always_ff @(posedge clk) begin
        if (rst) pipe_q <= {DEPTH{RST_VAL}};
        else     pipe_q <= pipe_d;
    end

    assign dout         = pipe_q[DEPTH];
    assign dout_pre_msb = pipe_q[DEPTH-1][WIDTH-1];
endmodule

// File: rtl/bram_scan_ctrl.sv
// Frame-buffer read controller: tracks incoming VGA timing, issues BRAM reads
// in flip/mirror order and re-aligns syncs with the expanded RGB888 pixels.
module bram_scan_ctrl
    import vga_pkg::*;
#(
    parameter int HSIZE     = HSIZE_DEF,
    parameter int VSIZE     = VSIZE_DEF,
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic              DE,
    input  logic              FLIP_V,
    input  logic              MIRROR_H,
    output logic [ADDR_W-1:0] BRAMADDR,
    output logic              BRAMEN,
    input  logic [15:0]       BRAMDATA,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              DE_OUT,
    output logic              HSYNC_OUT,
    output logic              VSYNC_OUT,
    output logic              ERR_HLEN,
    output logic              ERR_VLEN
);
    localparam int L      = RD_LAT + 2;
    localparam int COL_W  = clog2(HSIZE + 1);
    localparam int LINE_W = clog2(VSIZE + 1);

    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(HSIZE);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(HSIZE - 1);
    localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(VSIZE);
    localparam logic [ADDR_W-1:0] ROW_FIRST = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(BASE_ADDR + (VSIZE - 1) * HSIZE);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(HSIZE);

    logic [COL_W-1:0]  col_q, col_d, col_eff;
    logic [LINE_W-1:0] line_q, line_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mode_v_q, mode_v_d;
    logic              mode_h_q, mode_h_d;
    logic              de_d_q, de_d_d;
    logic              en_q, en_d;
    logic              err_h_q, err_h_d;
    logic              err_v_q, err_v_d;

    always_comb begin
        col_d      = col_q;
        line_d     = line_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        mode_v_d   = mode_v_q;
        mode_h_d   = mode_h_q;
        de_d_d     = DE;
        en_d       = 1'b0;
        err_h_d    = err_h_q;
        err_v_d    = err_v_q;
        col_eff    = mode_h_q ? COL_LAST - col_q : col_q;

        // Frame start outranks everything, including a coincident line end.
        if (!VSYNC) begin
            mode_v_d   = FLIP_V;
            mode_h_d   = MIRROR_H;
            col_d      = '0;
            line_d     = '0;
            de_d_d     = 1'b0;
            row_base_d = FLIP_V ? ROW_LAST : ROW_FIRST;
        end else if (DE) begin
            if (col_q < COL_MAX) col_d = col_q + 1'b1;
            else                 err_h_d = 1'b1;
            if (line_q >= LINE_MAX) err_v_d = 1'b1;
            if (col_q < COL_MAX && line_q < LINE_MAX) begin
                en_d   = 1'b1;
                addr_d = row_base_q + ADDR_W'(col_eff);
            end
        end else if (de_d_q) begin
            col_d = '0;
            if (line_q < LINE_MAX) begin
                line_d     = line_q + 1'b1;
                row_base_d = mode_v_q ? row_base_q - ROW_STEP : row_base_q + ROW_STEP;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            col_q      <= '0;
            line_q     <= '0;
            row_base_q <= ROW_FIRST;
            addr_q     <= '0;
            mode_v_q   <= 1'b0;
            mode_h_q   <= 1'b0;
            de_d_q     <= 1'b0;
            en_q       <= 1'b0;
            err_h_q    <= 1'b0;
            err_v_q    <= 1'b0;
        end else begin
            col_q      <= col_d;
            line_q     <= line_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            mode_v_q   <= mode_v_d;
            mode_h_q   <= mode_h_d;
            de_d_q     <= de_d_d;
            en_q       <= en_d;
            err_h_q    <= err_h_d;
            err_v_q    <= err_v_d;
        end
    end

    logic [2:0] sync_out;
    logic       de_pre;
    rgb888_t    rgb_q, rgb_d;

    sync_delay #(
        .DEPTH  (L),
        .WIDTH  (3),
        .RST_VAL(3'b011)
    ) u_sync_delay (
        .clk         (CLK),
        .rst         (RESET),
        .din         ({DE, HSYNC, VSYNC}),
        .dout        (sync_out),
        .dout_pre_msb(de_pre)
    );

    // BRAMDATA lines up with the delayed DE one stage before the output.
    always_comb begin
        rgb_d = de_pre ? rgb565_to_888(BRAMDATA) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) rgb_q <= '0;
        else       rgb_q <= rgb_d;
    end

    assign BRAMADDR                       = addr_q;
    assign BRAMEN                         = en_q;
    assign R                              = rgb_q.r;
    assign G                              = rgb_q.g;
    assign B                              = rgb_q.b;
    assign {DE_OUT, HSYNC_OUT, VSYNC_OUT} = sync_out;
    assign ERR_HLEN                       = err_h_q;
    assign ERR_VLEN                       = err_v_q;
endmodule

// File: tb/tb_bram_scan_ctrl.sv
// Directed bench for bram_scan_ctrl: a 4x3 frame with RD_LAT=1 (base 0x100)
// and RD_LAT=3 (base 0x7E0) instances driven by the same VGA timing.
module tb_bram_scan_ctrl;
    logic CLK = 1'b0;
    logic RESET, VSYNC, HSYNC, DE, FLIP_V, MIRROR_H;

    logic [11:0] a1, a3;
    logic        en1, en3, deo1, deo3, hso1, hso3, vso1, vso3, eh1, eh3, ev1, ev3;
    logic [7:0]  r1, g1, b1, r3, g3, b3;
    logic [15:0] d1, d3, d3_p1, d3_p2;

    logic [15:0] mem [4096];
    logic [2:0]  h [5];
    bit          mon_en = 1'b0;
    int          checks = 0, fails = 0;

    logic [11:0] q1[$], q3[$];
    logic [23:0] c1[$], c3[$];

    always #5 CLK = ~CLK;

    bram_scan_ctrl #(.HSIZE(4), .VSIZE(3), .ADDR_W(12), .BASE_ADDR('h100), .RD_LAT(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .VSYNC(VSYNC), .HSYNC(HSYNC), .DE(DE),
        .FLIP_V(FLIP_V), .MIRROR_H(MIRROR_H), .BRAMADDR(a1), .BRAMEN(en1), .BRAMDATA(d1),
        .R(r1), .G(g1), .B(b1), .DE_OUT(deo1), .HSYNC_OUT(hso1), .VSYNC_OUT(vso1),
        .ERR_HLEN(eh1), .ERR_VLEN(ev1));

    bram_scan_ctrl #(.HSIZE(4), .VSIZE(3), .ADDR_W(12), .BASE_ADDR('h7E0), .RD_LAT(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .VSYNC(VSYNC), .HSYNC(HSYNC), .DE(DE),
        .FLIP_V(FLIP_V), .MIRROR_H(MIRROR_H), .BRAMADDR(a3), .BRAMEN(en3), .BRAMDATA(d3),
        .R(r3), .G(g3), .B(b3), .DE_OUT(deo3), .HSYNC_OUT(hso3), .VSYNC_OUT(vso3),
        .ERR_HLEN(eh3), .ERR_VLEN(ev3));

    // BRAM models: one and three cycle read latency
    always @(posedge CLK) begin
        d1    <= mem[a1];
        d3_p1 <= mem[a3];
        d3_p2 <= d3_p1;
        d3    <= d3_p2;
    end

    // input history, cleared to inactive values on reset like the DUT pipe
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 5; i++) h[i] <= 3'b011;
        end else begin
            h[0] <= {DE, HSYNC, VSYNC};
            for (int i = 1; i < 5; i++) h[i] <= h[i-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp565(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("sync_lat3", 32'({deo1, hso1, vso1}), 32'(h[2]));
            chk("sync_lat5", 32'({deo3, hso3, vso3}), 32'(h[4]));
            if (!deo1) chk("rgb1_blank", 32'({r1, g1, b1}), 32'(0));
            if (!deo3) chk("rgb3_blank", 32'({r3, g3, b3}), 32'(0));
            if (en1) q1.push_back(a1);
            if (en3) q3.push_back(a3);
            if (deo1) c1.push_back({r1, g1, b1});
            if (deo3) c3.push_back({r3, g3, b3});
        end
    end

    task automatic cyc(input logic de, input logic hs, input logic vs);
        DE = de; HSYNC = hs; VSYNC = vs;
        @(posedge CLK); #1;
    endtask

    task automatic do_line(input int len);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        repeat (len) cyc(1, 1, 1);
        repeat (3) cyc(0, 1, 1);
    endtask

    // Mode inputs are inverted after VSYNC so any mid-frame sampling shows up.
    task automatic run_frame(input logic flip, input logic mir, input int nl,
                             input int l0, input int l1, input int l2, input int l3);
        int lens[4];
        lens = '{l0, l1, l2, l3};
        FLIP_V = flip; MIRROR_H = mir;
        repeat (2) cyc(0, 1, 0);
        FLIP_V = ~flip; MIRROR_H = ~mir;
        repeat (2) cyc(0, 1, 1);
        for (int l = 0; l < nl; l++) do_line(lens[l]);
        repeat (6) cyc(0, 1, 1);
    endtask

    task automatic clear_q();
        q1.delete(); q3.delete(); c1.delete(); c3.delete();
    endtask

    // exp holds the 12 expected addresses with entry 0 in exp[11]
    task automatic check_frame(input string tag, input logic [11:0][11:0] exp, input bit do_rgb);
        logic [11:0] e, e3;
        chk({tag, "_n1"}, 32'(q1.size()), 32'(12));
        chk({tag, "_n3"}, 32'(q3.size()), 32'(12));
        if (do_rgb) begin
            chk({tag, "_nrgb1"}, 32'(c1.size()), 32'(12));
            chk({tag, "_nrgb3"}, 32'(c3.size()), 32'(12));
        end
        for (int k = 0; k < 12; k++) begin
            e  = exp[11-k];
            e3 = e - 12'h100 + 12'h7E0;
            if (k < q1.size()) chk({tag, "_addr1"}, 32'(q1[k]), 32'(e));
            if (k < q3.size()) chk({tag, "_addr3"}, 32'(q3[k]), 32'(e3));
            if (do_rgb && k < c1.size()) chk({tag, "_rgb1"}, 32'(c1[k]), 32'(exp565(mem[e])));
            if (do_rgb && k < c3.size()) chk({tag, "_rgb3"}, 32'(c3[k]), 32'(exp565({4'h0, e3})));
        end
        clear_q();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_flags1"}, 32'({en1, deo1, hso1, vso1, eh1, ev1}), 32'(6'b001100));
        chk({tag, "_flags3"}, 32'({en3, deo3, hso3, vso3, eh3, ev3}), 32'(6'b001100));
        chk({tag, "_rgb1"}, 32'({r1, g1, b1}), 32'(0));
        chk({tag, "_rgb3"}, 32'({r3, g3, b3}), 32'(0));
        chk({tag, "_addr1"}, 32'(a1), 32'(0));
        chk({tag, "_addr3"}, 32'(a3), 32'(0));
    endtask

    typedef struct packed {
        logic              flip;
        logic              mirror;
        logic [11:0][11:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{flip: 1'b0, mirror: 1'b0, exp: {12'h100, 12'h101, 12'h102, 12'h103,
                    12'h104, 12'h105, 12'h106, 12'h107, 12'h108, 12'h109, 12'h10A, 12'h10B}};
        vecs[1] = '{flip: 1'b1, mirror: 1'b0, exp: {12'h108, 12'h109, 12'h10A, 12'h10B,
                    12'h104, 12'h105, 12'h106, 12'h107, 12'h100, 12'h101, 12'h102, 12'h103}};
        vecs[2] = '{flip: 1'b0, mirror: 1'b1, exp: {12'h103, 12'h102, 12'h101, 12'h100,
                    12'h107, 12'h106, 12'h105, 12'h104, 12'h10B, 12'h10A, 12'h109, 12'h108}};
        vecs[3] = '{flip: 1'b1, mirror: 1'b1, exp: {12'h10B, 12'h10A, 12'h109, 12'h108,
                    12'h107, 12'h106, 12'h105, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100}};

        for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
        mem[12'h100] = 16'hF800;

        RESET = 1'b1; DE = 1'b0; HSYNC = 1'b1; VSYNC = 1'b1; FLIP_V = 1'b0; MIRROR_H = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset("reset");
        RESET = 1'b0;
        mon_en = 1'b1;
        @(posedge CLK); #1;

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].flip, vecs[v].mirror, 3, 4, 4, 4, 0);
            if (v == 0) begin
                chk("f800_red", 32'(c1[0]), 32'(24'hFF0000));
                chk("07e0_green", 32'(c3[0]), 32'(24'h00FF00));
            end
            check_frame($sformatf("vec%0d", v), vecs[v].exp, 1'b1);
        end
        chk("no_err1", 32'({eh1, ev1}), 32'(0));
        chk("no_err3", 32'({eh3, ev3}), 32'(0));

        // over-long first line: 6 DE cycles, only 4 reads, next line at +4
        run_frame(0, 0, 3, 6, 4, 4, 0);
        chk("hlen_line1_start", 32'(q1[4]), 32'(12'h104));
        check_frame("hlen", vecs[0].exp, 1'b0);
        chk("hlen_err1", 32'({eh1, ev1}), 32'(2'b10));
        chk("hlen_err3", 32'({eh3, ev3}), 32'(2'b10));

        run_frame(0, 0, 3, 4, 4, 4, 0);
        check_frame("after_hlen", vecs[0].exp, 1'b1);
        chk("hlen_sticky", 32'({eh1, eh3}), 32'(2'b11));

        // fourth active line in a 3-line frame
        run_frame(0, 0, 4, 4, 4, 4, 4);
        check_frame("vlen", vecs[0].exp, 1'b0);
        chk("vlen_err1", 32'({eh1, ev1}), 32'(2'b11));
        chk("vlen_err3", 32'({eh3, ev3}), 32'(2'b11));

        // reset in the middle of the third line of a flipped frame
        clear_q();
        FLIP_V = 1'b1; MIRROR_H = 1'b0;
        repeat (2) cyc(0, 1, 0);
        repeat (2) cyc(0, 1, 1);
        do_line(4);
        do_line(4);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        repeat (2) cyc(1, 1, 1);
        RESET = 1'b1;
        cyc(1, 1, 1);
        @(negedge CLK); #1;
        chk("pre_reset_n", 32'(q1.size()), 32'(10));
        chk("pre_reset_last", 32'(q1[9]), 32'(12'h101));
        check_reset("midreset");
        RESET = 1'b0;
        clear_q();
        repeat (2) cyc(0, 1, 1);
        do_line(4);
        repeat (6) cyc(0, 1, 1);
        chk("post_reset_n1", 32'(q1.size()), 32'(4));
        chk("post_reset_n3", 32'(q3.size()), 32'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < q1.size()) chk("post_reset_addr1", 32'(q1[k]), 32'(12'h100 + k));
            if (k < q3.size()) chk("post_reset_addr3", 32'(q3[k]), 32'(12'h7E0 + k));
        end
        chk("post_reset_red", 32'(c1[0]), 32'(24'hFF0000));
        clear_q();
        run_frame(0, 0, 3, 4, 4, 4, 0);
        check_frame("after_reset", vecs[0].exp, 1'b1);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
